// File: rtl/spi_fsm.sv
// SPI slave transaction controller: turns conditioned SCLK edge pulses and chip select
// into shift-register, address-latch, data-memory and MISO-buffer controls.
module spi_fsm #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       sclkPosedge,
    input  logic       sclkNegedge,
    input  logic       rwBit,
    output logic       srEnable,
    output logic [1:0] srMode,
    output logic       addrWE,
    output logic       dmWE,
    output logic       misoEnable,
    output logic       busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_PLOAD = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        GET,
        ADDR,
        READ_LOAD,
        READ_SHIFT,
        WRITE_GET,
        WRITE_COMMIT,
        DONE
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] count, count_next, count_inc;

    // Saturating bit counter: a stray extra edge can never wrap it back to zero.
    assign count_inc = (count == FULL) ? count : count + CW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        srEnable   = 1'b0;
        srMode     = MODE_HOLD;
        addrWE     = 1'b0;
        dmWE       = 1'b0;
        misoEnable = 1'b0;
        busy       = (state != IDLE);

        // Chip select released mid-frame: drop everything so no partial write or latch occurs.
        if (state != IDLE && cs) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!cs) begin
                        state_next = GET;
                        count_next = '0;
                    end
                end
                GET, WRITE_GET: begin
                    if (sclkPosedge) begin
                        srEnable   = 1'b1;
                        srMode     = MODE_LEFT;
                        count_next = count_inc;
                        if (count_inc == FULL) begin
                            state_next = (state == GET) ? ADDR : WRITE_COMMIT;
                        end
                    end
                end
                ADDR: begin
                    addrWE     = 1'b1;
                    count_next = '0;
                    state_next = rwBit ? READ_LOAD : WRITE_GET;
                end
                READ_LOAD: begin
                    srEnable   = 1'b1;
                    srMode     = MODE_PLOAD;
                    count_next = '0;
                    state_next = READ_SHIFT;
                end
                READ_SHIFT: begin
                    // Shift on the falling edge so the next bit is stable before the master samples.
                    misoEnable = 1'b1;
                    if (sclkNegedge) begin
                        srEnable   = 1'b1;
                        srMode     = MODE_LEFT;
                        count_next = count_inc;
                        if (count_inc == FULL) begin
                            state_next = DONE;
                        end
                    end
                end
                WRITE_COMMIT: begin
                    dmWE       = 1'b1;
                    state_next = DONE;
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_fsm.sv
// Directed, table-driven bench for spi_fsm: one record per clk cycle holding the inputs
// and the outputs expected during that cycle.
module tb_spi_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cs = 1'b1;
    logic       sclk_pos = 1'b0;
    logic       sclk_neg = 1'b0;
    logic       rw = 1'b0;
    logic       sr_enable;
    logic [1:0] sr_mode;
    logic       addr_we;
    logic       dm_we;
    logic       miso_enable;
    logic       busy;

    int checks = 0;
    int errors = 0;

    spi_fsm #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .cs         (cs),
        .sclkPosedge(sclk_pos),
        .sclkNegedge(sclk_neg),
        .rwBit      (rw),
        .srEnable   (sr_enable),
        .srMode     (sr_mode),
        .addrWE     (addr_we),
        .dmWE       (dm_we),
        .misoEnable (miso_enable),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       cs;
        logic       pos;
        logic       neg;
        logic       rw;
        logic [6:0] exp;   // {srEnable, srMode[1:0], addrWE, dmWE, misoEnable, busy}
        bit         chk;
    } vec_t;

    vec_t tbl[$];

    localparam logic [6:0] O_IDLE  = 7'b0_00_0_0_0_0;
    localparam logic [6:0] O_BUSY  = 7'b0_00_0_0_0_1;
    localparam logic [6:0] O_SHIFT = 7'b1_10_0_0_0_1;
    localparam logic [6:0] O_ADDR  = 7'b0_00_1_0_0_1;
    localparam logic [6:0] O_DMWE  = 7'b0_00_0_1_0_1;
    localparam logic [6:0] O_PLOAD = 7'b1_11_0_0_0_1;
    localparam logic [6:0] O_MISO  = 7'b0_00_0_0_1_1;
    localparam logic [6:0] O_MSHFT = 7'b1_10_0_0_1_1;

    task automatic add(input logic r, input logic c, input logic p, input logic n,
                       input logic w, input logic [6:0] e, input bit chk);
        vec_t t;
        t.rst = r; t.cs = c; t.pos = p; t.neg = n; t.rw = w; t.exp = e; t.chk = chk;
        tbl.push_back(t);
    endtask

    // n posedge pulses in GET/WRITE_GET; negedge-only cycles between them must not shift.
    task automatic shift_in(input int n, input bit with_neg);
        for (int i = 0; i < n; i++) begin
            add(0, 0, 1, 0, 0, O_SHIFT, 1);
            if (with_neg && i != n - 1) add(0, 0, 0, 1, 0, O_BUSY, 1);
        end
    endtask

    // n bits out in READ_SHIFT: posedge cycles ignored, negedge cycles shift.
    task automatic shift_out(input int n);
        for (int i = 0; i < n; i++) begin
            add(0, 0, 1, 0, 0, O_MISO, 1);
            add(0, 0, 0, 1, 0, O_MSHFT, 1);
        end
    endtask

    task automatic step(input logic r, input logic c, input logic p, input logic n, input logic w);
        @(negedge clk);
        reset = r; cs = c; sclk_pos = p; sclk_neg = n; rw = w;
        #2;
    endtask

    task automatic check(input string name, input logic [6:0] exp);
        logic [6:0] act;
        act = {sr_enable, sr_mode, addr_we, dm_we, miso_enable, busy};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: outputs {en,mode,aWE,dWE,miso,busy} = %b, expected %b", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset, then idle
        add(1, 1, 0, 0, 0, O_IDLE, 0);
        add(1, 1, 0, 0, 0, O_IDLE, 1);
        add(0, 1, 1, 1, 0, O_IDLE, 1);

        // Write: address byte 0x54 (rw=0), data byte 0xA5, then DONE until cs rises
        add(0, 0, 0, 0, 0, O_IDLE, 1);
        add(0, 0, 0, 0, 0, O_BUSY, 1);
        shift_in(8, 1);
        add(0, 0, 0, 0, 0, O_ADDR, 1);
        shift_in(8, 1);
        add(0, 0, 0, 0, 0, O_DMWE, 1);
        add(0, 0, 1, 0, 0, O_BUSY, 1);
        add(0, 0, 0, 1, 0, O_BUSY, 1);
        add(0, 1, 1, 0, 0, O_BUSY, 1);

        // One IDLE cycle, then read of the same address (0x55, rw=1)
        add(0, 0, 0, 0, 1, O_IDLE, 1);
        shift_in(8, 1);
        add(0, 0, 0, 0, 1, O_ADDR, 1);
        add(0, 0, 1, 0, 0, O_PLOAD, 1);
        shift_out(8);
        add(0, 0, 1, 1, 0, O_BUSY, 1);
        add(0, 1, 0, 0, 0, O_BUSY, 1);
        add(0, 1, 0, 0, 0, O_IDLE, 1);

        // Abort after 4 WRITE_GET posedges: no dmWE afterwards
        add(0, 0, 0, 0, 0, O_IDLE, 1);
        shift_in(8, 0);
        add(0, 0, 0, 0, 0, O_ADDR, 1);
        shift_in(4, 1);
        add(0, 1, 1, 0, 0, O_BUSY, 1);
        add(0, 1, 1, 0, 0, O_IDLE, 1);
        add(0, 1, 0, 0, 0, O_IDLE, 1);

        // Reset mid-GET at count 5; fresh frame must need a full 8 posedges
        add(0, 0, 0, 0, 0, O_IDLE, 1);
        shift_in(5, 1);
        add(1, 0, 1, 0, 0, O_SHIFT, 0);
        add(0, 0, 1, 0, 0, O_IDLE, 1);
        shift_in(8, 0);
        add(0, 0, 0, 0, 1, O_ADDR, 1);
        // Abort during READ_LOAD suppresses the parallel load
        add(0, 1, 0, 0, 0, O_BUSY, 1);
        add(0, 1, 0, 0, 0, O_IDLE, 1);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].cs, tbl[i].pos, tbl[i].neg, tbl[i].rw);
            if (tbl[i].chk) check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Reset during READ_SHIFT drops misoEnable on the next cycle
        step(0, 0, 0, 0, 0);
        check("rd_start", O_IDLE);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1);
        check("rd_addr", O_ADDR);
        step(0, 0, 0, 0, 0);
        check("rd_pload", O_PLOAD);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        check("rd_mid_shift", O_MSHFT);
        step(1, 0, 0, 0, 0);
        check("rd_reset_cycle", O_MISO);
        step(0, 1, 0, 1, 0);
        check("rd_after_reset", O_IDLE);
        step(0, 1, 0, 0, 0);
        check("rd_idle", O_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_fsm.md
# spi_fsm

SPI slave transaction controller that sequences the 8-bit serial/parallel shift register in the SPI memory path. It turns conditioned SCLK edge pulses and chip select into shift-register enable/mode commands, address-latch and data-memory write strobes, and the MISO buffer enable. It sits between the input conditioners and the shift register, address latch and data memory.

## Interface
Parameters:
- `WIDTH`, 8: frame length in bits (address+R/W byte, data byte); counter width is `$clog2(WIDTH)+1`.

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high; sampled on posedge `clk`.
- `cs`  in  1  conditioned chip select, active low.
- `sclkPosedge`  in  1  one-`clk` pulse per SCLK rising edge.
- `sclkNegedge`  in  1  one-`clk` pulse per SCLK falling edge.
- `rwBit`  in  1  shift register `parallelOut[0]`; 1 = read, 0 = write.
- `srEnable`  out  1  drives the shift register's `serialClkposedge` enable.
- `srMode`  out  2  shift register mode: 00 HOLD, 01 RIGHT, 10 LEFT, 11 PLOAD.
- `addrWE`  out  1  one-cycle address latch write strobe.
- `dmWE`  out  1  one-cycle data memory write strobe.
- `misoEnable`  out  1  MISO tri-state buffer enable.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, GET, ADDR, READ_LOAD, READ_SHIFT, WRITE_GET, WRITE_COMMIT, DONE. Moore-style state register plus bit counter `count`; outputs decoded combinationally from state and edge inputs.
- Default outputs every cycle: `srEnable`=0, `srMode`=00, `addrWE`=`dmWE`=`misoEnable`=0.
- IDLE: `cs`=0 -> GET, `count`<=0. Edge pulses ignored.
- GET: on `sclkPosedge`: `srEnable`=1, `srMode`=10, `count`++. When `count` reaches `WIDTH` -> ADDR.
- ADDR (1 cycle): `addrWE`=1. `rwBit`=1 -> READ_LOAD; `rwBit`=0 -> WRITE_GET, `count`<=0.
- READ_LOAD (1 cycle): `srEnable`=1, `srMode`=11 (memory read data valid this cycle); -> READ_SHIFT, `count`<=0.
- READ_SHIFT: `misoEnable`=1 throughout. On `sclkNegedge`: `srEnable`=1, `srMode`=10, `count`++. `sclkPosedge` ignored. `count`=`WIDTH` -> DONE.
- WRITE_GET: identical to GET; `count`=`WIDTH` -> WRITE_COMMIT.
- WRITE_COMMIT (1 cycle): `dmWE`=1; -> DONE.
- DONE: all outputs default except `busy`; waits for `cs`=1.
- Abort: `cs`=1 in any non-IDLE state -> IDLE next cycle; in that cycle all strobes and `srEnable` forced 0 (no partial write, no address latch).
- `count` saturates at `WIDTH`; never wraps.

## Timing
- Reset: state IDLE, `count`=0, all outputs 0 (`srMode`=00, `busy`=0) from the first cycle after `reset` sampled high; reset mid-transaction drops `misoEnable` and suppresses any pending strobe.
- `srEnable`/`srMode` are combinational with the edge pulse: shift register updates on the same `clk` edge that ends the pulse cycle.
- `addrWE` asserts exactly 1 cycle after the cycle carrying the 8th GET posedge pulse; `rwBit` sampled in that ADDR cycle.
- Read: PLOAD 1 cycle after ADDR; first MISO bit (shift register MSB) valid from the cycle after READ_LOAD, before the first master-sampling SCLK rise.
- Write: `dmWE` asserts 1 cycle after the 8th WRITE_GET posedge pulse cycle.
- `cs` low->high->low with ≥1 IDLE cycle starts a fresh transaction; back-to-back without an IDLE cycle not supported.

## Test plan
- Reset: assert `reset` mid-GET with `count`=5 -> next cycle state IDLE, all outputs 0, `busy`=0.
- Write: `cs`=0, 8 posedges shifting 0x54 (addr 0x2A, rw=0), then 8 posedges of 0xA5 -> one `addrWE` pulse, 8 `srEnable` cycles with `srMode`=10 each phase, one `dmWE` pulse, then DONE until `cs`=1.
- Read: shift 0x55 (addr 0x2A, rw=1) -> `addrWE` pulse, next cycle `srMode`=11 with `srEnable`=1, then `misoEnable`=1 and `srEnable` only on the 8 negedge pulses; DONE after the 8th.
- Abort: raise `cs` after 4 WRITE_GET posedges -> IDLE next cycle, `dmWE` never asserts.
- Edge filtering: `sclkNegedge` pulses during GET and `sclkPosedge` pulses during READ_SHIFT -> `srEnable` stays 0 on those cycles; extra posedges in DONE -> no effect.
- Back-to-back: write transaction, one IDLE cycle, read of same address -> two `addrWE` pulses, one `dmWE`, one PLOAD.
